// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and the peak-tracker state encoding.
// Used by the peak finder, the magnitude stage and the tracker.
package fft_pkg;

  localparam int NSamplesDefault = 1024;
  localparam int WDefault        = 33;

  typedef enum logic [1:0] {
    SEARCH,
    CANDIDATE,
    LOCKED
  } trk_state_t;

endpackage

// File: rtl/fft_bin_to_hz.sv
// Registered bin-to-frequency conversion: (k*FsHz)>>NBits, saturated to FreqBits.
// One cycle of latency; clear drops any conversion in flight.
module fft_bin_to_hz #(
  parameter int NBits    = 10,
  parameter int FsHz     = 48000,
  parameter int FreqBits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [NBits-1:0]    bin_i,
  input  logic                valid_i,
  output logic [FreqBits-1:0] hz_o,
  output logic                valid_o
);

  localparam int PW = NBits + $clog2(FsHz + 1);
  localparam logic [PW-1:0] FsV   = PW'(FsHz);
  localparam logic [PW-1:0] MaxHz = PW'((64'd1 << FreqBits) - 64'd1);

  logic [PW-1:0]       prod;
  logic [PW-1:0]       shifted;
  logic [FreqBits-1:0] hz_d;
  logic [FreqBits-1:0] hz_q;
  logic                valid_q;

  assign prod    = PW'(bin_i) * FsV;
  assign shifted = prod >> NBits;
  assign hz_d    = (shifted > MaxHz) ? {FreqBits{1'b1}} : FreqBits'(shifted);

  // The last converted frequency is held between updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hz_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      hz_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        hz_q <= hz_d;
      end
    end
  end

  assign hz_o    = hz_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fft_peak_tracker.sv
// Debounces per-frame FFT peaks into a stable locked bin and its frequency in Hz.
// Weak or out-of-band peaks are gated; lock needs agreeing frames and survives brief misses.
module fft_peak_tracker
  import fft_pkg::*;
#(
  parameter int NSamples   = NSamplesDefault,
  parameter int W          = WDefault,
  parameter int NBits      = $clog2(NSamples),
  parameter int FsHz       = 48000,
  parameter int FreqBits   = 16,
  parameter int MinBin     = 2,
  parameter int BinTol     = 2,
  parameter int LockFrames = 3,
  parameter int MissFrames = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [W-1:0]        threshold,
  input  logic [W-1:0]        peak,
  input  logic [NBits-1:0]    peak_k,
  input  logic                peak_valid,
  output logic                locked,
  output logic [NBits-1:0]    lock_bin,
  output logic [FreqBits-1:0] freq_hz,
  output logic                freq_valid
);

  localparam int NB1   = NBits + 1;
  localparam int CntW  = $clog2(LockFrames + 1);
  localparam int MissW = $clog2(MissFrames + 1);

  localparam logic [NBits:0]    MinBinV  = NB1'(MinBin);
  localparam logic [NBits:0]    HalfBinV = NB1'(NSamples / 2);
  localparam logic [NBits:0]    BinTolV  = NB1'(BinTol);
  localparam logic [CntW-1:0]   CntLast  = CntW'(LockFrames - 1);
  localparam logic [MissW-1:0]  MissLast = MissW'(MissFrames - 1);

  trk_state_t       state_q, state_d;
  logic [NBits-1:0] cand_q, cand_d;
  logic [NBits-1:0] lock_bin_q, lock_bin_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic             upd_q, upd_d;
  logic             hit;
  logic             bad;

  // Extra bit keeps the absolute difference from wrapping.
  function automatic logic near(input logic [NBits-1:0] a, input logic [NBits-1:0] b);
    logic [NBits:0] diff;
    diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return diff <= BinTolV;
  endfunction

  assign hit = peak_valid && (peak >= threshold) &&
               ({1'b0, peak_k} >= MinBinV) && ({1'b0, peak_k} < HalfBinV);
  assign bad = peak_valid && !hit;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    miss_d     = miss_q;
    lock_bin_d = lock_bin_q;
    upd_d      = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (hit) begin
          cand_d = peak_k;
          cnt_d  = CntW'(1);
          if (LockFrames == 1) begin
            state_d    = LOCKED;
            lock_bin_d = peak_k;
            upd_d      = 1'b1;
            cnt_d      = '0;
            miss_d     = '0;
          end else begin
            state_d = CANDIDATE;
          end
        end
      end
      CANDIDATE: begin
        if (hit && near(peak_k, cand_q)) begin
          cand_d = peak_k;
          if (cnt_q == CntLast) begin
            state_d    = LOCKED;
            lock_bin_d = peak_k;
            upd_d      = 1'b1;
            cnt_d      = '0;
            miss_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (hit) begin
          cand_d = peak_k;
          cnt_d  = CntW'(1);
        end else if (bad) begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        // A far-off strong peak counts as a miss just like a weak one.
        if (hit && near(peak_k, lock_bin_q)) begin
          lock_bin_d = peak_k;
          miss_d     = '0;
          upd_d      = 1'b1;
        end else if (peak_valid) begin
          if (miss_q == MissLast) begin
            state_d = SEARCH;
            miss_d  = '0;
            cnt_d   = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Clear outranks a coincident frame, which is simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      cand_q     <= '0;
      cnt_q      <= '0;
      miss_q     <= '0;
      lock_bin_q <= '0;
      upd_q      <= 1'b0;
    end else if (clear) begin
      state_q    <= SEARCH;
      cand_q     <= '0;
      cnt_q      <= '0;
      miss_q     <= '0;
      lock_bin_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      lock_bin_q <= lock_bin_d;
      upd_q      <= upd_d;
    end
  end

  fft_bin_to_hz #(
    .NBits    (NBits),
    .FsHz     (FsHz),
    .FreqBits (FreqBits)
  ) u_bin_to_hz (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .bin_i   (lock_bin_q),
    .valid_i (upd_q),
    .hz_o    (freq_hz),
    .valid_o (freq_valid)
  );

  assign locked   = (state_q == LOCKED);
  assign lock_bin = lock_bin_q;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed bench for fft_peak_tracker: lock, tracking, miss tolerance, gating, reset/clear, pipelining.
// Expected frequencies are hand-computed as floor(k*48000/1024).
module tb_fft_peak_tracker;

  localparam int W     = 33;
  localparam int NBits = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [W-1:0]     threshold;
  logic [W-1:0]     peak;
  logic [NBits-1:0] peak_k;
  logic             peak_valid;
  logic             locked;
  logic [NBits-1:0] lock_bin;
  logic [15:0]      freq_hz;
  logic             freq_valid;

  int errors = 0;
  int checks = 0;

  int t2k[3]  = '{22, 23, 21};
  int t2hz[3] = '{1031, 1078, 984};

  fft_peak_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .threshold  (threshold),
    .peak       (peak),
    .peak_k     (peak_k),
    .peak_valid (peak_valid),
    .locked     (locked),
    .lock_bin   (lock_bin),
    .freq_hz    (freq_hz),
    .freq_valid (freq_valid)
  );

  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle peak strobe starting on a falling edge; returns on the next falling edge.
  task automatic applyStimulus(input int pk, input int k);
    peak       = W'(pk);
    peak_k     = NBits'(k);
    peak_valid = 1'b1;
    @(negedge clk);
    peak_valid = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    clear      = 1'b0;
    threshold  = W'(1000);
    peak       = '0;
    peak_k     = '0;
    peak_valid = 1'b0;
    #1;
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_lock_bin", 32'(lock_bin), 0);
    checkOutput("rst_freq_hz", 32'(freq_hz), 0);
    checkOutput("rst_freq_valid", 32'(freq_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Three agreeing frames at k=21 lock the tracker.
    applyStimulus(5000, 21);
    checkOutput("t1_f1_locked", 32'(locked), 0);
    applyStimulus(5000, 21);
    checkOutput("t1_f2_locked", 32'(locked), 0);
    applyStimulus(5000, 21);
    checkOutput("t1_f3_locked", 32'(locked), 1);
    checkOutput("t1_lock_bin", 32'(lock_bin), 21);
    checkOutput("t1_fv_early", 32'(freq_valid), 0);
    @(negedge clk);
    checkOutput("t1_fv", 32'(freq_valid), 1);
    checkOutput("t1_freq", 32'(freq_hz), 984);
    @(negedge clk);
    checkOutput("t1_fv_pulse", 32'(freq_valid), 0);

    // Tracking small bin moves while locked.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5000, t2k[i]);
      @(negedge clk);
      checkOutput($sformatf("t2_fv_%0d", i), 32'(freq_valid), 1);
      checkOutput($sformatf("t2_freq_%0d", i), 32'(freq_hz), 32'(t2hz[i]));
    end
    checkOutput("t2_locked", 32'(locked), 1);

    // Three weak frames are tolerated, a good frame resets the miss count.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(500, 21);
      @(negedge clk);
      checkOutput($sformatf("t3_weak_fv_%0d", i), 32'(freq_valid), 0);
      checkOutput($sformatf("t3_weak_locked_%0d", i), 32'(locked), 1);
    end
    applyStimulus(5000, 21);
    @(negedge clk);
    checkOutput("t3_recover_fv", 32'(freq_valid), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(500, 21);
      checkOutput($sformatf("t3_drop_locked_%0d", i), 32'(locked), (i < 3) ? 1 : 0);
    end
    @(negedge clk);
    checkOutput("t3_drop_fv", 32'(freq_valid), 0);
    checkOutput("t3_hold_freq", 32'(freq_hz), 984);
    checkOutput("t3_hold_bin", 32'(lock_bin), 21);

    // Gated frames never start a candidate; restart on a different tone.
    applyStimulus(5000, 1);
    applyStimulus(5000, 600);
    applyStimulus(999, 21);
    applyStimulus(5000, 21);
    applyStimulus(5000, 21);
    checkOutput("t4_reject_locked", 32'(locked), 0);
    applyStimulus(5000, 30);
    applyStimulus(1000, 30);
    checkOutput("t4_restart_locked", 32'(locked), 0);
    applyStimulus(5000, 30);
    checkOutput("t4_locked", 32'(locked), 1);
    checkOutput("t4_lock_bin", 32'(lock_bin), 30);
    @(negedge clk);
    checkOutput("t4_fv", 32'(freq_valid), 1);
    checkOutput("t4_freq", 32'(freq_hz), 1406);

    // Asynchronous reset while in CANDIDATE, between clock edges.
    for (int i = 0; i < 4; i++) applyStimulus(500, 30);
    applyStimulus(5000, 50);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_rst_locked", 32'(locked), 0);
    checkOutput("t5_rst_lock_bin", 32'(lock_bin), 0);
    checkOutput("t5_rst_freq", 32'(freq_hz), 0);
    checkOutput("t5_rst_fv", 32'(freq_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(5000, 50);
    applyStimulus(5000, 50);
    checkOutput("t5_postrst_locked", 32'(locked), 0);
    applyStimulus(5000, 50);
    checkOutput("t5_lock50", 32'(locked), 1);
    checkOutput("t5_lock50_bin", 32'(lock_bin), 50);

    // Clear the cycle after the lock strobe suppresses the pending freq_valid.
    pulseClear();
    checkOutput("t5_clr_fv", 32'(freq_valid), 0);
    checkOutput("t5_clr_locked", 32'(locked), 0);
    checkOutput("t5_clr_bin", 32'(lock_bin), 0);
    checkOutput("t5_clr_freq", 32'(freq_hz), 0);

    // Clear coincident with a strobe drops that frame.
    applyStimulus(5000, 60);
    applyStimulus(5000, 60);
    peak       = W'(5000);
    peak_k     = NBits'(60);
    peak_valid = 1'b1;
    clear      = 1'b1;
    @(negedge clk);
    peak_valid = 1'b0;
    clear      = 1'b0;
    checkOutput("t5_coinc_locked", 32'(locked), 0);
    applyStimulus(5000, 60);
    applyStimulus(5000, 60);
    checkOutput("t5_coinc_relock_early", 32'(locked), 0);
    applyStimulus(5000, 60);
    checkOutput("t5_coinc_relock", 32'(locked), 1);

    // Back-to-back strobes: lock on k=40, then consecutive updates at 41 and 42.
    pulseClear();
    peak       = W'(5000);
    peak_k     = NBits'(40);
    peak_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_locked", 32'(locked), 1);
    checkOutput("t6_fv_early", 32'(freq_valid), 0);
    peak_k = NBits'(41);
    @(negedge clk);
    checkOutput("t6_fv40", 32'(freq_valid), 1);
    checkOutput("t6_freq40", 32'(freq_hz), 1875);
    peak_k = NBits'(42);
    @(negedge clk);
    peak_valid = 1'b0;
    checkOutput("t6_fv41", 32'(freq_valid), 1);
    checkOutput("t6_freq41", 32'(freq_hz), 1921);
    @(negedge clk);
    checkOutput("t6_fv42", 32'(freq_valid), 1);
    checkOutput("t6_freq42", 32'(freq_hz), 1968);
    checkOutput("t6_bin42", 32'(lock_bin), 42);

    // Highest accepted bin converts without saturating.
    pulseClear();
    peak       = W'(5000);
    peak_k     = NBits'(511);
    peak_valid = 1'b1;
    repeat (3) @(negedge clk);
    peak_valid = 1'b0;
    checkOutput("t6_locked511", 32'(locked), 1);
    @(negedge clk);
    checkOutput("t6_fv511", 32'(freq_valid), 1);
    checkOutput("t6_freq511", 32'(freq_hz), 23953);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
